counter_with_load_case: RTL and testbench
=========================================

// Module: counter_with_load_case
//
// PURPOSE
// - Free-running up-counter with a synchronous parallel load.
// - Counts one step per rising clock edge.
// - Can be preset from an input word, or cleared by reset.
// - Generic building block for timers and sequence generators.
// - Next-state selection is coded as a case on the control pair {reset, load}.
//
// PARAMETERS
// - WIDTH  4  Counter and load-value width in bits; must be >= 1.
//
// PORTS
// - clk         input   1      Single clock; all state changes on its rising edge.
// - reset       input   1      Synchronous, active-low reset (0 = clear).
// - load        input   1      Synchronous load enable, active-high.
// - load_val_i  input   WIDTH  Value captured into the counter when loading.
// - count_o     output  WIDTH  Current count; driven directly from the register.
//
// BEHAVIOUR
// - Clock and reset:
//   - One clock domain: clk.
//   - reset is synchronous and active-low.
//   - It is sampled only on the rising edge of clk.
//   - There is no asynchronous clear.
// - Priority at each rising edge, highest first:
//   1. reset==0: count_o <= 0. load and load_val_i are ignored.
//   2. reset==1, load==1: count_o <= load_val_i.
//   3. reset==1, load==0: count_o <= count_o + 1, modulo 2^WIDTH.
// - Wrap-around: with WIDTH=4, 4'hF increments to 4'h0 with no flag or stall.
// - Latency:
//   - A loaded or cleared value appears on count_o one edge after sampling.
//   - Increments are visible one edge after each other.
//   - count_o is registered only; there is no combinational path from inputs to count_o.
// - Load mechanics:
//   - Load is level-sensitive. Holding load high reloads load_val_i every edge, so the count freezes at that value.
//   - The first increment happens on the first edge after load falls.
//   - Changes to load_val_i while load==0 have no effect.
// - Reset mid-count or mid-load: clears on the next edge. Counting resumes from 0 on the edge after reset returns high.
// - Power-up:
//   - count_o is undefined (X in simulation) until the first edge with reset==0.
//   - No initial value is relied on.
// - X handling: if reset or load is X/Z, the case default holds the current count.
//
// TESTING
// - Scenario 1, reset: reset=0 for 2 edges with load=1, load_val_i=4'hF -> count_o==4'h0 after the first edge.
// - Scenario 2, load: reset=1, load=1, load_val_i=4'h7 for 3 edges -> count_o==4'h7 and stays 4'h7.
// - Scenario 3, count: after scenario 2, load=0 for 3 edges while load_val_i toggles 4'hA/4'hF/4'h3 -> count_o goes 8, 9, A; load_val_i is ignored.
// - Scenario 4, wrap: load 4'hE, then count 3 edges -> count_o goes F, 0, 1.
// - Scenario 5, priority: reset=0 and load=1 with load_val_i=4'hA together, from count 4'h5 -> count_o==4'h0, not 4'hA.
// - Scenario 6, reset release: reset 0->1 with load=0 -> count_o goes 0, 1, 2 on successive edges. Check count_o only changes at rising edges.

Source files
------------

// File: rtl/counter_with_load_case.sv
// counter_with_load_case: up-counter with sync active-low clear and level-sensitive parallel load
module counter_with_load_case #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] count_o
);
    // Unknown controls fall to default and hold the count rather than corrupt it
    always_ff @(posedge clk) begin
        case ({reset, load})
            2'b00, 2'b01: count_o <= '0;
            2'b11:        count_o <= load_val_i;
            2'b10:        count_o <= count_o + 1'b1;
            default:      count_o <= count_o;
        endcase
    end
endmodule

// File: tb/tb_counter_with_load_case.sv
// tb_counter_with_load_case: directed vector table, corner sequences and random model check
module tb_counter_with_load_case;
    localparam int W = 4;
    typedef struct {
        logic         r;
        logic         l;
        logic [W-1:0] v;
        logic [W-1:0] exp;
    } vec_t;
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val_i = '0;
    logic [W-1:0] count_o;
    int checks = 0;
    int errors = 0;
    int model = 0;
    vec_t vecs[$];
    counter_with_load_case #(.WIDTH(W)) dut (
        .clk(clk),
        .reset(reset),
        .load(load),
        .load_val_i(load_val_i),
        .count_o(count_o)
    );
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s count_o=%h expected=%h at %0t", name, act, req, $time);
        end
    endtask
    // Apply inputs away from the edge, let one rising edge pass, update the model
    task automatic drive(input logic r, input logic l, input logic [W-1:0] v);
        @(negedge clk);
        reset = r;
        load = l;
        load_val_i = v;
        @(posedge clk);
        #1;
        model = !r ? 0 : l ? int'(v) : (model + 1) % (1 << W);
    endtask
    initial begin
        vecs.push_back('{1'b0, 1'b1, 4'hF, 4'h0});
        vecs.push_back('{1'b0, 1'b1, 4'hF, 4'h0});
        vecs.push_back('{1'b1, 1'b1, 4'h7, 4'h7});
        vecs.push_back('{1'b1, 1'b1, 4'h7, 4'h7});
        vecs.push_back('{1'b1, 1'b1, 4'h7, 4'h7});
        vecs.push_back('{1'b1, 1'b0, 4'hA, 4'h8});
        vecs.push_back('{1'b1, 1'b0, 4'hF, 4'h9});
        vecs.push_back('{1'b1, 1'b0, 4'h3, 4'hA});
        vecs.push_back('{1'b1, 1'b1, 4'hE, 4'hE});
        vecs.push_back('{1'b1, 1'b0, 4'h0, 4'hF});
        vecs.push_back('{1'b1, 1'b0, 4'h0, 4'h0});
        vecs.push_back('{1'b1, 1'b0, 4'h0, 4'h1});
        vecs.push_back('{1'b1, 1'b1, 4'h5, 4'h5});
        vecs.push_back('{1'b0, 1'b1, 4'hA, 4'h0});
        vecs.push_back('{1'b0, 1'b0, 4'h0, 4'h0});
        vecs.push_back('{1'b1, 1'b0, 4'h0, 4'h1});
        vecs.push_back('{1'b1, 1'b0, 4'h0, 4'h2});
        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].l, vecs[i].v);
            check($sformatf("vec%0d", i), count_o, vecs[i].exp);
            #3;
            check($sformatf("vec%0d_hold", i), count_o, vecs[i].exp);
        end
        // Reset mid-count, then a held load freezes while load_val_i is steady
        drive(1'b1, 1'b1, 4'h3);
        check("mid_load", count_o, 4'h3);
        drive(1'b1, 1'b0, 4'hC);
        check("mid_cnt1", count_o, 4'h4);
        drive(1'b1, 1'b0, 4'hC);
        check("mid_cnt2", count_o, 4'h5);
        drive(1'b0, 1'b0, 4'hC);
        check("mid_reset", count_o, 4'h0);
        drive(1'b1, 1'b1, 4'h9);
        check("freeze1", count_o, 4'h9);
        drive(1'b1, 1'b1, 4'h9);
        check("freeze2", count_o, 4'h9);
        drive(1'b1, 1'b0, 4'h9);
        check("after_load", count_o, 4'hA);
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0, W'($urandom));
            check("random", count_o, W'(model));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
